// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind a UART receiver: sync hunt, length, payload streaming, XOR checksum check.
// Every output is registered, one cycle after the causing byte strobe. An inter-byte timeout aborts a stalled frame.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 1740,
    localparam int        IW           = $clog2(MAX_LEN + 1),
    localparam int        TW           = $clog2(TIMEOUT_CLKS) + 1
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_Payload_DV,
    output logic [7:0]    o_Payload_Byte,
    output logic [IW-1:0] o_Payload_Index,
    output logic          o_Frame_Done,
    output logic          o_Frame_OK,
    output logic [1:0]    o_Err_Code,
    output logic          o_Busy
);

    typedef enum logic [1:0] {HUNT, GET_LEN, GET_PAYLOAD, GET_CSUM} state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;
    localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t          r_state, w_state;
    logic [7:0]      r_len, w_len;
    logic [7:0]      r_csum, w_csum;
    logic [IW-1:0]   r_index, w_index;
    logic [TW-1:0]   r_timer, w_timer;
    logic            r_payload_dv, w_payload_dv;
    logic [7:0]      r_payload_byte, w_payload_byte;
    logic [IW-1:0]   r_payload_index, w_payload_index;
    logic            r_frame_done, w_frame_done;
    logic            r_frame_ok, w_frame_ok;
    logic [1:0]      r_err_code, w_err_code;
    logic            r_busy, w_busy;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state         <= HUNT;
            r_len           <= '0;
            r_csum          <= '0;
            r_index         <= '0;
            r_timer         <= '0;
            r_payload_dv    <= 1'b0;
            r_payload_byte  <= '0;
            r_payload_index <= '0;
            r_frame_done    <= 1'b0;
            r_frame_ok      <= 1'b0;
            r_err_code      <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_len           <= w_len;
            r_csum          <= w_csum;
            r_index         <= w_index;
            r_timer         <= w_timer;
            r_payload_dv    <= w_payload_dv;
            r_payload_byte  <= w_payload_byte;
            r_payload_index <= w_payload_index;
            r_frame_done    <= w_frame_done;
            r_frame_ok      <= w_frame_ok;
            r_err_code      <= w_err_code;
            r_busy          <= w_busy;
        end
    end

    always_comb begin
        w_state         = r_state;
        w_len           = r_len;
        w_csum          = r_csum;
        w_index         = r_index;
        w_timer         = r_timer;
        w_payload_dv    = 1'b0;
        w_payload_byte  = r_payload_byte;
        w_payload_index = r_payload_index;
        w_frame_done    = 1'b0;
        w_frame_ok      = r_frame_ok;
        w_err_code      = r_err_code;

        // A byte strobe always takes priority over timer expiry in the same cycle.
        if (i_RX_DV) begin
            w_timer = '0;
            case (r_state)
                HUNT: begin
                    if (i_RX_Byte == SYNC_BYTE) begin
                        w_state = GET_LEN;
                    end
                end
                GET_LEN: begin
                    w_len  = i_RX_Byte;
                    w_csum = i_RX_Byte;
                    if (i_RX_Byte == 8'd0 || i_RX_Byte > MAX_LEN_B) begin
                        w_frame_done = 1'b1;
                        w_frame_ok   = 1'b0;
                        w_err_code   = ERR_LEN;
                        w_state      = HUNT;
                    end else begin
                        w_index = '0;
                        w_state = GET_PAYLOAD;
                    end
                end
                GET_PAYLOAD: begin
                    w_payload_dv    = 1'b1;
                    w_payload_byte  = i_RX_Byte;
                    w_payload_index = r_index;
                    w_csum          = r_csum ^ i_RX_Byte;
                    if (8'(r_index) == r_len - 8'd1) begin
                        w_state = GET_CSUM;
                    end else begin
                        w_index = r_index + 1'b1;
                    end
                end
                GET_CSUM: begin
                    w_frame_done = 1'b1;
                    w_state      = HUNT;
                    if (i_RX_Byte == r_csum) begin
                        w_frame_ok = 1'b1;
                        w_err_code = ERR_OK;
                    end else begin
                        w_frame_ok = 1'b0;
                        w_err_code = ERR_CSUM;
                    end
                end
                default: w_state = HUNT;
            endcase
        end else if (r_state != HUNT) begin
            if (r_timer == TIMER_LAST) begin
                w_frame_done = 1'b1;
                w_frame_ok   = 1'b0;
                w_err_code   = ERR_TIMEOUT;
                w_state      = HUNT;
            end else if (r_timer != TIMER_MAX) begin
                w_timer = r_timer + 1'b1;
            end
        end

        if (w_state == HUNT) begin
            w_timer = '0;
        end
        w_busy = (w_state != HUNT);
    end

    assign o_Payload_DV    = r_payload_dv;
    assign o_Payload_Byte  = r_payload_byte;
    assign o_Payload_Index = r_payload_index;
    assign o_Frame_Done    = r_frame_done;
    assign o_Frame_OK      = r_frame_ok;
    assign o_Err_Code      = r_err_code;
    assign o_Busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized frames for uart_rx_frame_ctrl, compared every cycle against a byte-level frame model.
module tb_uart_rx_frame_ctrl;
    localparam int T    = 1740;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] rxb = 8'h00;
    logic       o_pdv, o_done, o_ok, o_busy;
    logic [7:0] o_pb;
    logic [4:0] o_pi;
    logic [1:0] o_err;

    int total = 0;
    int bad   = 0;
    int timeouts = 0;

    uart_rx_frame_ctrl dut (
        .i_Clock(clk), .i_Reset(rst), .i_RX_DV(dv), .i_RX_Byte(rxb),
        .o_Payload_DV(o_pdv), .o_Payload_Byte(o_pb), .o_Payload_Index(o_pi),
        .o_Frame_Done(o_done), .o_Frame_OK(o_ok), .o_Err_Code(o_err), .o_Busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: phase 0 hunting, 1 waiting length, 2 payload, 3 checksum.
    int         m_phase = 0, m_len = 0, m_got = 0, m_idle = 0;
    logic [7:0] m_sum = 0;
    logic       e_pdv = 0, e_done = 0, e_ok = 0;
    logic [7:0] e_pb = 0;
    int         e_pi = 0;
    logic [1:0] e_err = 0;

    always @(posedge clk) begin
        e_pdv  = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_phase = 0; m_len = 0; m_got = 0; m_idle = 0; m_sum = 0;
            e_ok = 0; e_err = 0;
        end else if (dv) begin
            m_idle = 0;
            case (m_phase)
                0: if (rxb == 8'hA5) m_phase = 1;
                1: begin
                    m_len = rxb;
                    m_sum = rxb;
                    if (m_len == 0 || m_len > MAXL) begin
                        e_done = 1; e_ok = 0; e_err = 2'd1; m_phase = 0;
                    end else begin
                        m_got = 0; m_phase = 2;
                    end
                end
                2: begin
                    e_pdv = 1; e_pb = rxb; e_pi = m_got;
                    m_sum = m_sum ^ rxb;
                    m_got++;
                    if (m_got == m_len) m_phase = 3;
                end
                default: begin
                    e_done = 1; e_ok = (rxb == m_sum); e_err = e_ok ? 2'd0 : 2'd2; m_phase = 0;
                end
            endcase
        end else if (m_phase != 0) begin
            m_idle++;
            if (m_idle == T) begin
                e_done = 1; e_ok = 0; e_err = 2'd3; m_phase = 0; m_idle = 0;
            end
        end
        #1;
        chk("model_done", o_done, e_done);
        chk("model_pdv", o_pdv, e_pdv);
        chk("model_ok", o_ok, e_ok);
        chk("model_err", o_err, e_err);
        chk("model_busy", o_busy, m_phase != 0);
        if (e_pdv) begin
            chk("model_pbyte", o_pb, e_pb);
            chk("model_pidx", o_pi, e_pi);
        end
    end

    // Called at a falling edge; the byte is sampled on the next rising edge and its effect is visible on return.
    task automatic send(input logic [7:0] b);
        dv  = 1'b1;
        rxb = b;
        @(negedge clk);
        dv  = 1'b0;
        rxb = 8'($urandom);
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    initial begin
        logic [7:0] q[$];
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_ok", o_ok, 0);
        chk("reset_err", o_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Good frame
        send_q('{8'hA5, 8'h03});
        chk("t1_busy_mid", o_busy, 1);
        send(8'h11); chk("t1_pdv0", o_pdv, 1); chk("t1_pb0", o_pb, 8'h11); chk("t1_pi0", o_pi, 0);
        send(8'h22); chk("t1_pb1", o_pb, 8'h22); chk("t1_pi1", o_pi, 1);
        send(8'h33); chk("t1_pb2", o_pb, 8'h33); chk("t1_pi2", o_pi, 2);
        send(8'h03);
        chk("t1_done", o_done, 1); chk("t1_ok", o_ok, 1); chk("t1_err", o_err, 0); chk("t1_busy", o_busy, 0);
        @(negedge clk);
        chk("t1_done_pulse", o_done, 0); chk("t1_ok_held", o_ok, 1);

        // Bad checksum
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        chk("t2_done", o_done, 1); chk("t2_ok", o_ok, 0); chk("t2_err", o_err, 2);

        // Bad lengths
        send_q('{8'hA5, 8'h00});
        chk("t3_len0_done", o_done, 1); chk("t3_len0_err", o_err, 1); chk("t3_len0_busy", o_busy, 0);
        send_q('{8'hA5, 8'h11});
        chk("t3_len17_done", o_done, 1); chk("t3_len17_err", o_err, 1);
        send(8'h5A);
        chk("t3_ignored_busy", o_busy, 0); chk("t3_ignored_done", o_done, 0);

        // Timeout latency counted in rising edges after the last byte
        send_q('{8'hA5, 8'h02, 8'h11});
        n = 0;
        while (o_done !== 1'b1 && n < T + 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_timeout_latency", n, T);
        chk("t4_err", o_err, 3); chk("t4_ok", o_ok, 0);

        // Byte landing exactly on the expiry cycle keeps the frame alive
        send_q('{8'hA5, 8'h02, 8'h11});
        repeat (T - 1) @(negedge clk);
        send(8'h22);
        chk("t4_rescue_pdv", o_pdv, 1); chk("t4_rescue_pi", o_pi, 1); chk("t4_rescue_busy", o_busy, 1);
        send(8'h31);
        chk("t4_rescue_done", o_done, 1); chk("t4_rescue_ok", o_ok, 1);

        // Junk before sync, then back-to-back repeat
        send_q('{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h5A});
        chk("t5_pb", o_pb, 8'h5A); chk("t5_pi", o_pi, 0);
        send(8'h5B);
        chk("t5_done", o_done, 1); chk("t5_ok", o_ok, 1);
        send_q('{8'hA5, 8'h01, 8'h5A, 8'h5B});
        chk("t5_rep_done", o_done, 1); chk("t5_rep_ok", o_ok, 1);

        // Reset mid-frame
        send_q('{8'hA5, 8'h03, 8'h11});
        rst = 1'b1;
        #1;
        chk("t6_busy", o_busy, 0); chk("t6_pdv", o_pdv, 0); chk("t6_ok", o_ok, 0);
        chk("t6_err", o_err, 0); chk("t6_done", o_done, 0); chk("t6_pb", o_pb, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_q('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        chk("t6_after_done", o_done, 1); chk("t6_after_ok", o_ok, 1);

        // Randomized frames: good, bad length, bad checksum, stalled near the timeout edge
        for (int f = 0; f < 80; f++) begin
            int kind, len, cut;
            logic [7:0] sum, b;
            kind = $urandom_range(0, 9);
            q.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                q.push_back(b == 8'hA5 ? 8'h00 : b);
            end
            q.push_back(8'hA5);
            cut = q.size();
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255);
                q.push_back(8'(len));
            end else begin
                len = $urandom_range(1, MAXL);
                q.push_back(8'(len));
                sum = 8'(len);
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom);
                    q.push_back(b);
                    sum ^= b;
                end
                if (kind == 1) sum ^= 8'($urandom_range(1, 255));
                q.push_back(sum);
            end
            if (kind == 2 && timeouts < 6) begin
                timeouts++;
                cut = $urandom_range(cut, q.size() - 2);
            end else begin
                cut = -1;
            end
            foreach (q[i]) begin
                send(q[i]);
                if (i == cut) repeat ($urandom_range(T - 3, T + 2)) @(negedge clk);
                else if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
